// File: rtl/reg_file_nxw.sv
// reg_file_nxw: NREGS x WIDTH register bank with load/clear/inc/dec write port, two read ports and wrap flag
module reg_file_nxw #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             wrap
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] cur, nxt;
  logic wa_ok, wrap_nxt, byp0, byp1;
  always_comb begin
    wa_ok = int'(wa) < NREGS;
    cur = wa_ok ? regs[wa] : '0;
    nxt = op == 2'b00 ? d : op == 2'b01 ? '0 : op == 2'b10 ? cur + WIDTH'(1) : cur - WIDTH'(1);
    wrap_nxt = wa_ok && (op == 2'b10 ? &cur : op == 2'b11 ? ~|cur : 1'b0);
    // forwarding is suppressed during reset so the ports read zero immediately
    byp0 = BYPASS != 0 && en && rst_n && wa_ok && ra0 == wa;
    byp1 = BYPASS != 0 && en && rst_n && wa_ok && ra1 == wa;
    q0 = byp0 ? nxt : int'(ra0) < NREGS ? regs[ra0] : '0;
    q1 = byp1 ? nxt : int'(ra1) < NREGS ? regs[ra1] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      if (wa_ok) regs[wa] <= nxt;
      wrap <= wrap_nxt;
    end
endmodule
